// File: rtl/ram_port_arbiter_if.sv
// Bus bundle for the port-A arbiter: CPU side, SPI loader side, RAM port A and status.
interface ram_port_arbiter_if;
  logic        cpu_ce;
  logic        cpu_mreq;
  logic        cpu_wr;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic        cpu_wait_n;

  logic        spi_wr;
  logic        spi_rd;
  logic [31:0] spi_addr;
  logic [7:0]  spi_wdata;
  logic [7:0]  spi_rdata;

  logic        ram_we;
  logic [15:0] ram_addr;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;

  logic [7:0]  ctrl;
  logic        spi_ovf;

  modport slave (
    input  cpu_ce, cpu_mreq, cpu_wr, cpu_addr, cpu_dout,
    input  spi_wr, spi_rd, spi_addr, spi_wdata,
    input  ram_dout,
    output cpu_din, cpu_wait_n, spi_rdata,
    output ram_we, ram_addr, ram_din,
    output ctrl, spi_ovf
  );

  modport master (
    output cpu_ce, cpu_mreq, cpu_wr, cpu_addr, cpu_dout,
    output spi_wr, spi_rd, spi_addr, spi_wdata,
    output ram_dout,
    input  cpu_din, cpu_wait_n, spi_rdata,
    input  ram_we, ram_addr, ram_din,
    input  ctrl, spi_ovf
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Shares dual-port RAM port A between the Z80 and the SPI loader, owns the
// SPI-mapped control register and stalls the CPU while the loader holds the port.
module ram_port_arbiter #(
  parameter logic [7:0] CTRL_INIT   = 8'h00,
  parameter bit         ROM_PROTECT = 1'b1
) (
  input logic               clk,
  input logic               reset,
  ram_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_ACC, S_CAP} state_t;

  localparam logic [7:0] PAGE_RAM  = 8'h00;
  localparam logic [7:0] PAGE_CTRL = 8'hFF;

  state_t      r_state, w_state;
  logic        r_own_cpu, w_own_cpu;
  logic        r_acc_wr, w_acc_wr;
  logic        r_spi_pend, w_spi_pend;
  logic        r_spi_is_wr, w_spi_is_wr;
  logic [7:0]  r_spi_page, w_spi_page;
  logic [15:0] r_spi_ram_addr, w_spi_ram_addr;
  logic [7:0]  r_spi_wdata, w_spi_wdata;
  logic        r_cpu_served, w_cpu_served;
  logic [7:0]  r_ctrl, w_ctrl;
  logic        r_spi_ovf, w_spi_ovf;
  logic        r_ram_we, w_ram_we;
  logic [15:0] r_ram_addr, w_ram_addr;
  logic [7:0]  r_ram_din, w_ram_din;
  logic [7:0]  r_cpu_din, w_cpu_din;
  logic [7:0]  r_spi_rdata, w_spi_rdata;
  logic        r_cpu_wait_n, w_cpu_wait_n;

  logic w_strobe;
  logic w_rom_hit;
  logic w_cpu_elig;
  logic w_unused_bits;

  assign w_unused_bits = ^bus.spi_addr[23:16];

  assign w_strobe  = bus.spi_wr | bus.spi_rd;
  assign w_rom_hit = ROM_PROTECT && (bus.cpu_addr[15:14] == 2'b00);
  // A strobe arriving this cycle also holds off the CPU so the loader wins ties.
  assign w_cpu_elig = bus.cpu_mreq & ~r_cpu_served & ~r_ctrl[1] & ~w_strobe;

  always_comb begin
    w_state        = r_state;
    w_own_cpu      = r_own_cpu;
    w_acc_wr       = r_acc_wr;
    w_spi_pend     = r_spi_pend;
    w_spi_is_wr    = r_spi_is_wr;
    w_spi_page     = r_spi_page;
    w_spi_ram_addr = r_spi_ram_addr;
    w_spi_wdata    = r_spi_wdata;
    w_cpu_served   = r_cpu_served & ~bus.cpu_ce;
    w_ctrl         = r_ctrl;
    w_spi_ovf      = r_spi_ovf;
    w_ram_we       = 1'b0;
    w_ram_addr     = r_ram_addr;
    w_ram_din      = r_ram_din;
    w_cpu_din      = r_cpu_din;
    w_spi_rdata    = r_spi_rdata;

    case (r_state)
      S_IDLE: begin
        if (r_spi_pend && (r_spi_page == PAGE_RAM)) begin
          w_ram_addr = r_spi_ram_addr;
          w_ram_din  = r_spi_wdata;
          w_ram_we   = r_spi_is_wr;
          w_acc_wr   = r_spi_is_wr;
          w_own_cpu  = 1'b0;
          w_state    = S_ACC;
        end else begin
          // Register-page and unmapped-page requests finish here without the RAM.
          if (r_spi_pend) begin
            w_spi_pend = 1'b0;
            if (r_spi_page == PAGE_CTRL) begin
              if (r_spi_is_wr) w_ctrl = r_spi_wdata;
              else             w_spi_rdata = r_ctrl;
            end else if (!r_spi_is_wr) begin
              w_spi_rdata = 8'hFF;
            end
          end
          if (w_cpu_elig) begin
            w_ram_addr   = bus.cpu_addr;
            w_ram_din    = bus.cpu_dout;
            w_ram_we     = bus.cpu_wr & ~w_rom_hit;
            w_acc_wr     = bus.cpu_wr;
            w_own_cpu    = 1'b1;
            w_cpu_served = 1'b1;
            w_state      = S_ACC;
          end
        end
      end
      S_ACC: begin
        if (r_acc_wr) begin
          w_state = S_IDLE;
          if (!r_own_cpu) w_spi_pend = 1'b0;
        end else begin
          w_state = S_CAP;
        end
      end
      S_CAP: begin
        if (r_own_cpu) begin
          w_cpu_din = bus.ram_dout;
        end else begin
          w_spi_rdata = bus.ram_dout;
          w_spi_pend  = 1'b0;
        end
        w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase

    if (w_strobe) begin
      if (r_spi_pend) begin
        w_spi_ovf = 1'b1;
      end else begin
        w_spi_pend     = 1'b1;
        w_spi_is_wr    = bus.spi_wr;
        w_spi_page     = bus.spi_addr[31:24];
        w_spi_ram_addr = bus.spi_addr[15:0];
        w_spi_wdata    = bus.spi_wdata;
      end
    end

    w_cpu_wait_n = ~(w_ctrl[1] | (bus.cpu_mreq & ~w_cpu_served) |
                     (w_own_cpu & (w_state != S_IDLE)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_own_cpu      <= 1'b0;
      r_acc_wr       <= 1'b0;
      r_spi_pend     <= 1'b0;
      r_spi_is_wr    <= 1'b0;
      r_spi_page     <= 8'h00;
      r_spi_ram_addr <= 16'h0000;
      r_spi_wdata    <= 8'h00;
      r_cpu_served   <= 1'b0;
      r_ctrl         <= CTRL_INIT;
      r_spi_ovf      <= 1'b0;
      r_ram_we       <= 1'b0;
      r_ram_addr     <= 16'h0000;
      r_ram_din      <= 8'h00;
      r_cpu_din      <= 8'h00;
      r_spi_rdata    <= 8'h00;
      r_cpu_wait_n   <= ~CTRL_INIT[1];
    end else begin
      r_state        <= w_state;
      r_own_cpu      <= w_own_cpu;
      r_acc_wr       <= w_acc_wr;
      r_spi_pend     <= w_spi_pend;
      r_spi_is_wr    <= w_spi_is_wr;
      r_spi_page     <= w_spi_page;
      r_spi_ram_addr <= w_spi_ram_addr;
      r_spi_wdata    <= w_spi_wdata;
      r_cpu_served   <= w_cpu_served;
      r_ctrl         <= w_ctrl;
      r_spi_ovf      <= w_spi_ovf;
      r_ram_we       <= w_ram_we;
      r_ram_addr     <= w_ram_addr;
      r_ram_din      <= w_ram_din;
      r_cpu_din      <= w_cpu_din;
      r_spi_rdata    <= w_spi_rdata;
      r_cpu_wait_n   <= w_cpu_wait_n;
    end
  end

  assign bus.cpu_din    = r_cpu_din;
  assign bus.cpu_wait_n = r_cpu_wait_n;
  assign bus.spi_rdata  = r_spi_rdata;
  assign bus.ram_we     = r_ram_we;
  assign bus.ram_addr   = r_ram_addr;
  assign bus.ram_din    = r_ram_din;
  assign bus.ctrl       = r_ctrl;
  assign bus.spi_ovf    = r_spi_ovf;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed scenarios plus randomized CPU/loader traffic against a memory-level reference.
module tb_ram_port_arbiter;
  logic clk;
  logic reset;
  ram_port_arbiter_if bus ();

  ram_port_arbiter #(.CTRL_INIT(8'h00), .ROM_PROTECT(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int we_cnt   = 0;
  int rom_viol = 0;
  logic mem_init;
  logic [7:0] mem [0:65535];
  logic [7:0] ref_mem [logic [15:0]];

  function automatic logic [7:0] init_val(input logic [15:0] a);
    return 8'(a[7:0] * 3 + a[15:8] * 7 + 8'h5A);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [15:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_val(a);
  endfunction

  // Synchronous RAM behind port A, plus write-pulse bookkeeping.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 65536; i++) mem[i] <= init_val(16'(i));
    end else if (bus.ram_we) begin
      mem[bus.ram_addr] <= bus.ram_din;
    end
    bus.ram_dout <= mem[bus.ram_addr];
    if (bus.ram_we) begin
      we_cnt <= we_cnt + 1;
      if (bus.ram_addr[15:14] == 2'b00) rom_viol <= rom_viol + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic spi_drive(input logic wr, input logic [31:0] a, input logic [7:0] d);
    bus.spi_wr    = wr;
    bus.spi_rd    = ~wr;
    bus.spi_addr  = a;
    bus.spi_wdata = d;
  endtask

  task automatic cpu_drive(input logic req, input logic wr, input logic [15:0] a,
                           input logic [7:0] d);
    bus.cpu_ce   = 1'b1;
    bus.cpu_mreq = req;
    bus.cpu_wr   = wr;
    bus.cpu_addr = a;
    bus.cpu_dout = d;
  endtask

  task automatic clear_pulses();
    bus.spi_wr = 1'b0;
    bus.spi_rd = 1'b0;
    bus.cpu_ce = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  int          w0, lows, exp_writes;
  int          cop, sop, k;
  logic [15:0] ca, sa;
  logic [7:0]  cd, sd, m_ctrl, exp_c, exp_s;
  logic [31:0] sfull;

  initial begin
    reset = 1'b1;
    mem_init = 1'b1;
    bus.cpu_ce = 1'b0; bus.cpu_mreq = 1'b0; bus.cpu_wr = 1'b0;
    bus.cpu_addr = 16'h0; bus.cpu_dout = 8'h0;
    bus.spi_wr = 1'b0; bus.spi_rd = 1'b0; bus.spi_addr = 32'h0; bus.spi_wdata = 8'h0;
    tick();
    mem_init = 1'b0;
    tick();
    check("rst_ram_we", 32'(bus.ram_we), 32'h0);
    check("rst_ram_addr", 32'(bus.ram_addr), 32'h0);
    check("rst_ram_din", 32'(bus.ram_din), 32'h0);
    check("rst_cpu_din", 32'(bus.cpu_din), 32'h0);
    check("rst_spi_rdata", 32'(bus.spi_rdata), 32'h0);
    check("rst_ctrl", 32'(bus.ctrl), 32'h0);
    check("rst_ovf", 32'(bus.spi_ovf), 32'h0);
    check("rst_wait_n", 32'(bus.cpu_wait_n), 32'h1);
    reset = 1'b0;
    tick();

    // SPI write then read back
    spi_drive(1'b1, 32'h0000_4000, 8'hA5); tick(); clear_pulses();
    check("spiwr_not_yet", 32'(bus.ram_we), 32'h0);
    tick();
    check("spiwr_we", 32'(bus.ram_we), 32'h1);
    check("spiwr_addr", 32'(bus.ram_addr), 32'h4000);
    check("spiwr_din", 32'(bus.ram_din), 32'hA5);
    tick();
    check("spiwr_we_drop", 32'(bus.ram_we), 32'h0);
    ref_mem[16'h4000] = 8'hA5;
    tick();
    spi_drive(1'b0, 32'h0000_4000, 8'h00); tick(); clear_pulses();
    tick(); tick();
    check("spird_early", 32'(bus.spi_rdata), 32'h0);
    tick();
    check("spird_data", 32'(bus.spi_rdata), 32'(ref_rd(16'h4000)));

    // Control register blocks the CPU
    spi_drive(1'b1, 32'hFF00_0000, 8'h02); tick(); clear_pulses();
    tick();
    check("ctrl_val", 32'(bus.ctrl), 32'h02);
    check("ctrl_wait", 32'(bus.cpu_wait_n), 32'h0);
    check("ctrl_no_we", 32'(bus.ram_we), 32'h0);
    bus.cpu_mreq = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_addr = 16'hC123;
    lows = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!bus.cpu_wait_n) lows++;
    end
    check("ctrl_block_addr", 32'(bus.ram_addr), 32'h4000);
    check("ctrl_block_wait", 32'(lows), 32'd40);
    spi_drive(1'b1, 32'hFF00_0000, 8'h00); tick(); clear_pulses();
    tick();
    check("ctrl_clear", 32'(bus.ctrl), 32'h00);
    tick();
    check("ctrl_release_grant", 32'(bus.ram_addr), 32'hC123);
    tick(); tick();
    check("ctrl_release_din", 32'(bus.cpu_din), 32'(ref_rd(16'hC123)));
    check("ctrl_release_wait", 32'(bus.cpu_wait_n), 32'h1);
    cpu_drive(1'b0, 1'b0, 16'h0, 8'h0); tick(); clear_pulses();
    tick();

    // ROM protect
    w0 = we_cnt;
    cpu_drive(1'b1, 1'b1, 16'h1000, 8'h55); tick(); clear_pulses();
    repeat (6) tick();
    check("rom_no_we", 32'(we_cnt), 32'(w0));
    check("rom_wait", 32'(bus.cpu_wait_n), 32'h1);
    cpu_drive(1'b0, 1'b0, 16'h0, 8'h0); tick(); clear_pulses();
    cpu_drive(1'b1, 1'b1, 16'h8000, 8'h55); tick(); clear_pulses();
    check("ram_wr_we", 32'(bus.ram_we), 32'h1);
    check("ram_wr_addr", 32'(bus.ram_addr), 32'h8000);
    check("ram_wr_din", 32'(bus.ram_din), 32'h55);
    ref_mem[16'h8000] = 8'h55;
    repeat (6) tick();
    cpu_drive(1'b0, 1'b0, 16'h0, 8'h0); tick(); clear_pulses();
    tick();

    // Collision: loader read and CPU read in the same cycle
    spi_drive(1'b0, 32'h0000_0010, 8'h00);
    cpu_drive(1'b1, 1'b0, 16'h9000, 8'h00);
    tick(); clear_pulses();
    check("col_wait0", 32'(bus.cpu_wait_n), 32'h0);
    tick();
    check("col_spi_first", 32'(bus.ram_addr), 32'h0010);
    tick(); tick();
    check("col_spi_data", 32'(bus.spi_rdata), 32'(ref_rd(16'h0010)));
    tick();
    check("col_cpu_grant", 32'(bus.ram_addr), 32'h9000);
    tick();
    check("col_wait_cap", 32'(bus.cpu_wait_n), 32'h0);
    tick();
    check("col_cpu_data", 32'(bus.cpu_din), 32'(ref_rd(16'h9000)));
    check("col_wait_rel", 32'(bus.cpu_wait_n), 32'h1);
    tick();
    cpu_drive(1'b0, 1'b0, 16'h0, 8'h0); tick(); clear_pulses();
    tick();

    // Overflow: back-to-back strobes
    w0 = we_cnt;
    spi_drive(1'b1, 32'h0000_4100, 8'h11); tick();
    spi_drive(1'b1, 32'h0000_4200, 8'h22); tick(); clear_pulses();
    check("ovf_set", 32'(bus.spi_ovf), 32'h1);
    check("ovf_first_addr", 32'(bus.ram_addr), 32'h4100);
    check("ovf_first_din", 32'(bus.ram_din), 32'h11);
    repeat (4) tick();
    check("ovf_one_write", 32'(we_cnt), 32'(w0 + 1));
    check("ovf_sticky", 32'(bus.spi_ovf), 32'h1);
    ref_mem[16'h4100] = 8'h11;

    // Reset while a read sits in CAP
    spi_drive(1'b0, 32'h0000_4100, 8'h00); tick(); clear_pulses();
    tick(); tick();
    reset = 1'b1;
    #1;
    check("arst_ram_addr", 32'(bus.ram_addr), 32'h0);
    check("arst_spi_rdata", 32'(bus.spi_rdata), 32'h0);
    check("arst_ovf", 32'(bus.spi_ovf), 32'h0);
    check("arst_wait", 32'(bus.cpu_wait_n), 32'h1);
    check("arst_we", 32'(bus.ram_we), 32'h0);
    tick();
    check("arst_no_capture", 32'(bus.spi_rdata), 32'h0);
    reset = 1'b0;
    tick();

    // Randomized traffic: one CPU op and at most one loader op per CPU period
    m_ctrl = 8'h00;
    exp_writes = 0;
    w0 = we_cnt;
    for (int p = 0; p < 150; p++) begin
      cop = int'($urandom_range(0, 2));
      ca  = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 16'h3FFF))
                                          : 16'($urandom_range(16'h8000, 16'hFFFF));
      cd  = 8'($urandom);
      sop = int'($urandom_range(0, 6));
      k   = int'($urandom_range(0, 2));
      sa  = 16'($urandom_range(16'h4000, 16'h7FFF));
      sd  = 8'($urandom);
      case (sop)
        1, 2:    sfull = {16'h0000, sa};
        3:       begin sfull = {8'hFF, 24'($urandom)}; sd = sd & 8'hFD; end
        4:       sfull = {8'hFF, 24'($urandom)};
        default: sfull = {8'($urandom_range(1, 254)), 24'($urandom)};
      endcase
      for (int c = 0; c < 8; c++) begin
        if (c == 0) cpu_drive(cop != 0, cop == 2, ca, cd);
        if (c == k && sop != 0) spi_drive(sop == 1 || sop == 3 || sop == 5, sfull, sd);
        tick();
        clear_pulses();
      end
      exp_c = ref_rd(ca);
      if (cop == 1) check("rnd_cpu_rd", 32'(bus.cpu_din), 32'(exp_c));
      if (cop == 2 && ca[15:14] != 2'b00) begin
        ref_mem[ca] = cd;
        exp_writes++;
      end
      case (sop)
        1: begin ref_mem[sa] = sd; exp_writes++; end
        2: begin exp_s = ref_rd(sa); check("rnd_spi_rd", 32'(bus.spi_rdata), 32'(exp_s)); end
        3: m_ctrl = sd;
        4: check("rnd_ctrl_rd", 32'(bus.spi_rdata), 32'(m_ctrl));
        6: check("rnd_other_rd", 32'(bus.spi_rdata), 32'hFF);
        default: ;
      endcase
      check("rnd_wait", 32'(bus.cpu_wait_n), 32'h1);
    end
    cpu_drive(1'b0, 1'b0, 16'h0, 8'h0); tick(); clear_pulses();
    repeat (4) tick();
    check("rnd_ctrl", 32'(bus.ctrl), 32'(m_ctrl));
    check("rnd_write_count", 32'(we_cnt - w0), 32'(exp_writes));
    check("rnd_rom_writes", 32'(rom_viol), 32'h0);
    check("rnd_no_ovf", 32'(bus.spi_ovf), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
